// File: rtl/note_pkg.sv
// Shared definitions for the note-streaming link: duration codes, delay table,
// transmitter FSM encoding and the on-wire byte layout.
package note_pkg;

  localparam logic [2:0] DUR_NONE  = 3'd0;
  localparam logic [2:0] DUR_200MS = 3'd1;
  localparam logic [2:0] DUR_500MS = 3'd2;
  localparam logic [2:0] DUR_1S    = 3'd3;
  localparam logic [2:0] DUR_2S    = 3'd4;
  localparam logic [2:0] DUR_4S    = 3'd5;

  localparam int MS_W = 13;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_PACE  = 3'd4;

  typedef struct packed {
    logic [4:0] tone;
    logic [2:0] dur;
  } note_t;

  // Unused codes (0, 6, 7) map to zero so the player never stalls on them.
  function automatic logic [MS_W-1:0] dur_to_ms(input logic [2:0] code);
    logic [MS_W-1:0] ms;
    case (code)
      DUR_200MS: ms = 13'd200;
      DUR_500MS: ms = 13'd500;
      DUR_1S:    ms = 13'd1000;
      DUR_2S:    ms = 13'd2000;
      DUR_4S:    ms = 13'd4000;
      default:   ms = 13'd0;
    endcase
    return ms;
  endfunction

  function automatic note_t pack_note(input logic [4:0] tone, input logic [2:0] dur);
    note_t n;
    n.tone = tone;
    n.dur  = dur;
    return n;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous note buffer; pointers wrap naturally because DEPTH is a power of two.
module note_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_uart_tx.sv
// Note-command UART transmitter: buffers {tone,dur} notes and sends each as an
// 8N1 byte, optionally holding off the next byte for the note's duration.
module note_uart_tx
  import note_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 8,
  parameter int TICKS_PER_MS = CLK_FREQ / 1000
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [4:0]                    note_tone,
  input  logic [2:0]                    note_dur,
  input  logic                          pace_en,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int TICK_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [TICK_W-1:0] tick_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [MS_W-1:0]   delay_ms;
  logic [2:0]        dur_r;
  note_t             shift_r;
  note_t             fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              bit_done;
  logic              pace_done;

  note_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (note_valid),
    .wr_data   (pack_note(note_tone, note_dur)),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign note_ready = ~fifo_full;
  assign delay_ms   = dur_to_ms(dur_r);
  assign bit_done   = (baud_cnt == BAUD_LAST);
  // PACE is only entered with a nonzero delay, so delay_ms-1 never underflows here.
  assign pace_done  = (tick_cnt >= TICK_LAST) && (ms_cnt >= delay_ms - 13'd1);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: if (bit_done) state_nxt = ST_DATA;
      ST_DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP: begin
        if (bit_done)
          state_nxt = (pace_en && delay_ms != '0) ? ST_PACE : ST_IDLE;
      end
      ST_PACE:  if (pace_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Frame data: loaded on the pop cycle, never reset.
  always_ff @(posedge sys_clk) begin
    if (fifo_pop) begin
      shift_r <= fifo_rd;
      dur_r   <= fifo_rd.dur;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tick_cnt <= '0;
      ms_cnt   <= '0;
      tx_busy  <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      state   <= state_nxt;
      tx_busy <= (state_nxt != ST_IDLE);

      if ((state == ST_START || state == ST_DATA || state == ST_STOP) && !bit_done)
        baud_cnt <= baud_cnt + 1'b1;
      else
        baud_cnt <= '0;

      if (state != ST_DATA)
        bit_idx <= '0;
      else if (bit_done)
        bit_idx <= bit_idx + 1'b1;

      if (state != ST_PACE) begin
        tick_cnt <= '0;
        ms_cnt   <= '0;
      end else if (tick_cnt >= TICK_LAST) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      // Line level follows the state one clock later, from a register.
      case (state)
        ST_START: uart_txd <= 1'b0;
        ST_DATA:  uart_txd <= shift_r[bit_idx];
        default:  uart_txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_note_uart_tx.sv
// Scoreboard bench for note_uart_tx: pushes expected bytes on each accepted note,
// a line monitor decodes uart_txd frames and compares them in order.
module tb_note_uart_tx;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       note_valid;
  logic       note_ready;
  logic [4:0] note_tone;
  logic [2:0] note_dur;
  logic       pace_en;
  logic       uart_txd;
  logic       tx_busy;
  logic [3:0] fifo_count;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_push = 0;
  int         p0;
  int         t;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       mon_act = 1'b0;
  int         mon_off = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_last = 8'h00;
  logic [7:0] exp_b;
  logic [2:0] burst_dur [9] = '{3'd5, 3'd0, 3'd6, 3'd7, 3'd1, 3'd3, 3'd0, 3'd2, 3'd4};

  note_uart_tx #(
    .CLK_FREQ     (400),
    .BAUD         (100),
    .FIFO_DEPTH   (8),
    .TICKS_PER_MS (2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_tone  (note_tone),
    .note_dur   (note_dur),
    .pace_en    (pace_en),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Line monitor: offsets count negedges from the first low sample of a start bit.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (uart_txd === 1'b0) begin
        mon_act = 1'b1;
        mon_off = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_off++;
      if (mon_off == 2)
        chk("start_bit", uart_txd, 0);
      else if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2)
        mon_byte = {uart_txd, mon_byte[7:1]};
      else if (mon_off == 38) begin
        chk("stop_bit", uart_txd, 1);
        mon_last = mon_byte;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%02h, nothing queued", mon_byte);
        end else begin
          exp_b = exp_q.pop_front();
          chk("byte", mon_byte, exp_b);
        end
        mon_act = 1'b0;
      end
    end
  end

  task automatic push(input logic [4:0] tn, input logic [2:0] d);
    int w;
    w = 0;
    @(negedge sys_clk);
    note_valid = 1'b1;
    note_tone  = tn;
    note_dur   = d;
    while (!note_ready && w < 20000) begin
      @(negedge sys_clk);
      w++;
    end
    if (!note_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: note_ready=%0d after %0d cycles, required 1", note_ready, w);
      note_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    #1;
    last_push = cyc;
    exp_q.push_back({tn, d});
    note_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound);
    int w;
    w = 0;
    while (start_q.size() < n && w < bound) begin
      @(negedge sys_clk);
      w++;
    end
    if (start_q.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: %0d start bits seen, %0d required", start_q.size(), n);
    end
  endtask

  task automatic wait_busy_fall(output int tf);
    int w;
    w = 0;
    while (!tx_busy && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    w = 0;
    while (tx_busy && w < 20000) begin
      @(negedge sys_clk);
      w++;
    end
    tf = cyc;
    if (tx_busy) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: tx_busy=%0d, required 0", tx_busy);
    end
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while ((tx_busy || fifo_count != 0 || mon_act) && w < bound) begin
      @(negedge sys_clk);
      w++;
    end
    if (tx_busy || fifo_count != 0 || mon_act) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy=%0d count=%0d, required 0 0", tx_busy, fifo_count);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n  = 1'b0;
    note_valid = 1'b0;
    note_tone  = '0;
    note_dur   = '0;
    pace_en    = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", note_ready, 1);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Single note, 0x51
    start_q.delete();
    push(5'd10, 3'd1);
    wait_starts(1, 200);
    if (start_q.size() >= 1) chk("single_start_lat", start_q[0] - last_push, 2);
    wait_busy_fall(t);
    chk("single_busy_fall", t - last_push, 41);
    wait_idle(200);

    // Back-to-back, no pacing
    start_q.delete();
    push(5'd3, 3'd4);
    p0 = last_push;
    push(5'd17, 3'd2);
    wait_starts(2, 300);
    if (start_q.size() >= 2) begin
      chk("b2b_start_lat", start_q[0] - p0, 2);
      chk("b2b_gap", start_q[1] - start_q[0], 41);
    end
    wait_idle(300);

    // Paced: dur=2 -> 500 ms * 2 ticks, then dur=0
    pace_en = 1'b1;
    start_q.delete();
    push(5'd6, 3'd2);
    push(5'd21, 3'd0);
    wait_starts(2, 3000);
    if (start_q.size() >= 2) begin
      chk("pace_gap", start_q[1] - start_q[0], 1041);
      wait_busy_fall(t);
      chk("pace_busy_fall", t - start_q[1], 39);
    end
    repeat (5) @(negedge sys_clk);
    chk("pace_no_pace_after_dur0", tx_busy, 0);
    wait_idle(300);

    // Codes 0/6/7 never pace
    start_q.delete();
    push(5'd1, 3'd0);
    push(5'd2, 3'd6);
    push(5'd31, 3'd7);
    wait_starts(3, 500);
    if (start_q.size() >= 3) begin
      chk("code6_gap", start_q[1] - start_q[0], 41);
      chk("code7_gap", start_q[2] - start_q[1], 41);
    end
    wait_idle(300);

    // Burst fill while the first note paces for 4 s; pace_en dropped mid-PACE
    start_q.delete();
    for (int i = 0; i < 9; i++) push(5'(i + 1), burst_dur[i]);
    chk("burst_count_full", fifo_count, 8);
    chk("burst_ready_low", note_ready, 0);
    wait_starts(1, 100);
    while (start_q.size() >= 1 && cyc < start_q[0] + 60) @(negedge sys_clk);
    pace_en = 1'b0;
    wait_starts(9, 12000);
    if (start_q.size() >= 9) begin
      chk("burst_pace_gap", start_q[1] - start_q[0], 8041);
      chk("burst_gap2", start_q[2] - start_q[1], 41);
      chk("burst_gap_last", start_q[8] - start_q[7], 41);
    end
    wait_idle(2000);
    repeat (50) @(negedge sys_clk);
    chk("burst_frames", start_q.size(), 9);

    // Reset in the middle of data bit 3 of 0x63
    start_q.delete();
    push(5'd12, 3'd3);
    push(5'd5, 3'd0);
    wait_starts(1, 100);
    while (start_q.size() >= 1 && cyc < start_q[0] + 17) @(negedge sys_clk);
    chk("pre_rst_txd", uart_txd, 0);
    chk("pre_rst_count", fifo_count, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", uart_txd, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", tx_busy, 0);
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Clean frame after reset: tone 13, dur 1 -> 0x69
    start_q.delete();
    push(5'd13, 3'd1);
    wait_starts(1, 200);
    if (start_q.size() >= 1) chk("post_rst_start_lat", start_q[0] - last_push, 2);
    wait_idle(300);
    chk("loop_byte", mon_last, 8'h69);
    chk("loop_tone", mon_last[7:3], 13);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
